// File: rtl/rv32i_top.sv
// rv32i_top: single-cycle RV32I core (fetch, decode, regfile, ALU, data memory, next-PC).
// Every instruction commits PC, register and memory writes on one rising edge.
// Synchronous active-low reset clears pc and the register file; memories are preserved.
// Optional macro RV32I_TRACE_EN: prints "PC=0x%08h Instr=0x%08h" per executed non-zero word.
// Memory depths are expected to be powers of two no larger than 1024 words, so the
// word index taken from addr[11:2] wraps naturally.

module rv32i_imem #(
  parameter int WORDS = 1024
) (
  input  logic                       clk,
  input  logic                       load_en,
  input  logic [$clog2(WORDS)-1:0]   load_addr,
  input  logic [31:0]                load_data,
  input  logic [31:0]                addr,
  output logic [31:0]                rdata
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] memory [0:WORDS-1];
  logic        unused_addr;

  // Write port for a boot loader; tied off by the core, which runs preloaded code
  always_ff @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign rdata       = memory[addr[2 +: AW]];
  assign unused_addr = ^{addr[31:2+AW], addr[1:0]};
endmodule

module rv32i_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata
);
  logic [31:0] registers [0:31];

  // Clear all registers on reset; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && rd != 5'd0) begin
      registers[rd] <= wdata;
    end
  end

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : registers[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : registers[rs2];
endmodule

module rv32i_dmem #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(WORDS);

  logic [31:0]   memory [0:WORDS-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[2 +: AW];
  assign unused_addr = ^{addr[31:2+AW], addr[1:0]};

  // Byte-lane write: only enabled lanes change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) memory[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = memory[idx];
endmodule

module rv32i_top #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input logic clk,
  input logic reset
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, instruction, pc_plus4, next_pc;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_opimm, is_op;
  logic [31:0] alu_b, alu_out;
  logic [4:0]  shamt;
  logic        br_taken;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data;
  logic [3:0]  mem_be;
  logic        mem_we, reg_we;
  logic [31:0] rd_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  rv32i_imem #(.WORDS(IMEM_WORDS)) instruction_mem (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (32'd0),
    .addr      (pc),
    .rdata     (instruction)
  );

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Decode with full funct3/funct7 validation; anything else falls through as a NOP
  always_comb begin
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_opimm  = 1'b0;
    is_op     = 1'b0;
    case (opcode)
      OP_LUI:    is_lui    = 1'b1;
      OP_AUIPC:  is_auipc  = 1'b1;
      OP_JAL:    is_jal    = 1'b1;
      OP_JALR:   is_jalr   = (funct3 == 3'b000);
      OP_BRANCH: is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:   is_load   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                          || (funct3 == 3'b100) || (funct3 == 3'b101);
      OP_STORE:  is_store  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_IMM: begin
        if (funct3 == 3'b001)      is_opimm = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) is_opimm = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       is_opimm = 1'b1;
      end
      OP_REG: begin
        if (funct7 == 7'b0000000)      is_op = 1'b1;
        else if (funct7 == 7'b0100000) is_op = (funct3 == 3'b000) || (funct3 == 3'b101);
        else                           is_op = 1'b0;
      end
      default: ;
    endcase
  end

  rv32i_regfile registers (
    .clk      (clk),
    .reset    (reset),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (reg_we),
    .rd       (rd),
    .wdata    (rd_data)
  );

  assign alu_b = is_op ? rs2_data : imm_i;
  assign shamt = alu_b[4:0];

  // ALU: funct7[5] selects SUB only for register ops, SRA for both shift forms
  always_comb begin
    alu_out = 32'd0;
    case (funct3)
      3'b000: alu_out = (is_op && funct7[5]) ? rs1_data - alu_b : rs1_data + alu_b;
      3'b001: alu_out = rs1_data << shamt;
      3'b010: alu_out = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011: alu_out = {31'd0, rs1_data < alu_b};
      3'b100: alu_out = rs1_data ^ alu_b;
      3'b101: alu_out = funct7[5] ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110: alu_out = rs1_data | alu_b;
      3'b111: alu_out = rs1_data & alu_b;
      default: ;
    endcase
  end

  // Branch condition from funct3
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_data == rs2_data);
      3'b001: br_taken = (rs1_data != rs2_data);
      3'b100: br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101: br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: br_taken = (rs1_data <  rs2_data);
      3'b111: br_taken = (rs1_data >= rs2_data);
      default: ;
    endcase
  end

  assign mem_addr = rs1_data + (is_store ? imm_s : imm_i);
  assign mem_we   = is_store && reset;

  // Store lane enables and replicated write data
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = rs2_data;
    case (funct3)
      3'b000: begin
        mem_be    = 4'b0001 << mem_addr[1:0];
        mem_wdata = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        mem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{rs2_data[15:0]}};
      end
      3'b010: mem_be = 4'b1111;
      default: ;
    endcase
  end

  rv32i_dmem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Load lane select and sign/zero extension
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign reg_we   = reset && (is_op || is_opimm || is_load || is_lui || is_auipc || is_jal || is_jalr);

  // Writeback source select
  always_comb begin
    rd_data = alu_out;
    if (is_load)               rd_data = load_data;
    else if (is_jal || is_jalr) rd_data = pc_plus4;
    else if (is_lui)           rd_data = imm_u;
    else if (is_auipc)         rd_data = pc + imm_u;
  end

  // Next-PC select
  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)                     next_pc = pc + imm_j;
    else if (is_branch && br_taken) next_pc = pc + imm_b;
    else if (is_jalr)               next_pc = (rs1_data + imm_i) & ~32'd1;
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!reset) pc <= 32'd0;
    else        pc <= next_pc;
  end

`ifdef RV32I_TRACE_EN
  // Execution trace of each retiring non-zero instruction word
  always @(posedge clk) begin
    if (reset && instruction != 32'd0)
      $display("%0t PC=0x%08h Instr=0x%08h", $time, pc, instruction);
  end
`endif
endmodule

// File: tb/tb_rv32i_top.sv
// Directed bench for rv32i_top: hand-assembled programs with hand-computed results.
module tb_rv32i_top;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [31:0] prog [$];

  rv32i_top dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  // Hold reset, swap in the program, release on a falling edge
  task automatic load_and_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1024; i++)
      dut.instruction_mem.memory[i] = (i < prog.size()) ? prog[i] : 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_initial();
    prog = '{};
    load_and_reset();
    tests_run++;
    if (dut.pc !== 32'd0) begin
      tests_failed++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'd0);
    end
    tests_run++;
    if (dut.registers.registers[5] !== 32'd0) begin
      tests_failed++; $display("FAIL reset_x5 got %h want %h", dut.registers.registers[5], 32'd0);
    end
  endtask

  task automatic test_rtype();
    prog = '{enc_i(32'd5, 0, 3'b000, 1, OPI),
             enc_i(32'd3, 0, 3'b000, 2, OPI),
             enc_r(7'b0100000, 2, 1, 3'b000, 3),
             enc_r(7'b0000000, 2, 1, 3'b001, 4),
             enc_r(7'b0000000, 1, 2, 3'b010, 5),
             enc_r(7'b0000000, 2, 1, 3'b100, 6),
             enc_r(7'b0000000, 2, 1, 3'b110, 7),
             enc_r(7'b0000000, 2, 1, 3'b111, 8)};
    load_and_reset();
    run(4);
    tests_run++;
    if (dut.pc !== 32'h10) begin
      tests_failed++; $display("FAIL rtype_pc got %h want %h", dut.pc, 32'h10);
    end
    tests_run++;
    if (dut.registers.registers[3] !== 32'h2) begin
      tests_failed++; $display("FAIL rtype_sub got %h want %h", dut.registers.registers[3], 32'h2);
    end
    tests_run++;
    if (dut.registers.registers[4] !== 32'h28) begin
      tests_failed++; $display("FAIL rtype_sll got %h want %h", dut.registers.registers[4], 32'h28);
    end
    run(4);
    tests_run++;
    if (dut.registers.registers[5] !== 32'h1) begin
      tests_failed++; $display("FAIL rtype_slt got %h want %h", dut.registers.registers[5], 32'h1);
    end
    tests_run++;
    if (dut.registers.registers[6] !== 32'h6) begin
      tests_failed++; $display("FAIL rtype_xor got %h want %h", dut.registers.registers[6], 32'h6);
    end
    tests_run++;
    if (dut.registers.registers[7] !== 32'h7) begin
      tests_failed++; $display("FAIL rtype_or got %h want %h", dut.registers.registers[7], 32'h7);
    end
    tests_run++;
    if (dut.registers.registers[8] !== 32'h1) begin
      tests_failed++; $display("FAIL rtype_and got %h want %h", dut.registers.registers[8], 32'h1);
    end
  endtask

  task automatic test_itype();
    prog = '{enc_i(32'hFFFFFFFF, 0, 3'b000, 1, OPI),
             enc_i(32'd1, 1, 3'b011, 2, OPI),
             enc_i(32'h404, 1, 3'b101, 3, OPI),
             enc_i(32'd28, 1, 3'b101, 4, OPI),
             enc_i(32'd0, 1, 3'b010, 5, OPI),
             enc_i(32'd5, 0, 3'b000, 0, OPI)};
    load_and_reset();
    run(6);
    tests_run++;
    if (dut.registers.registers[1] !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL itype_addi got %h want %h", dut.registers.registers[1], 32'hFFFFFFFF);
    end
    tests_run++;
    if (dut.registers.registers[2] !== 32'h0) begin
      tests_failed++; $display("FAIL itype_sltiu got %h want %h", dut.registers.registers[2], 32'h0);
    end
    tests_run++;
    if (dut.registers.registers[3] !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL itype_srai got %h want %h", dut.registers.registers[3], 32'hFFFFFFFF);
    end
    tests_run++;
    if (dut.registers.registers[4] !== 32'hF) begin
      tests_failed++; $display("FAIL itype_srli got %h want %h", dut.registers.registers[4], 32'hF);
    end
    tests_run++;
    if (dut.registers.registers[5] !== 32'h1) begin
      tests_failed++; $display("FAIL itype_slti got %h want %h", dut.registers.registers[5], 32'h1);
    end
    tests_run++;
    if (dut.registers.registers[0] !== 32'h0) begin
      tests_failed++; $display("FAIL itype_x0 got %h want %h", dut.registers.registers[0], 32'h0);
    end
  endtask

  task automatic test_loadstore();
    prog = '{enc_u(32'h12345, 1, 7'b0110111),
             enc_i(32'h678, 1, 3'b000, 1, OPI),
             enc_s(32'd0, 1, 0, 3'b010),
             enc_i(32'd0, 0, 3'b000, 2, LD),
             enc_i(32'd2, 0, 3'b101, 3, LD),
             enc_s(32'd1, 0, 0, 3'b000),
             enc_i(32'd0, 0, 3'b010, 4, LD),
             enc_i(32'hFFFFFF80, 0, 3'b000, 5, OPI),
             enc_s(32'd4, 0, 0, 3'b010),
             enc_s(32'd4, 5, 0, 3'b000),
             enc_s(32'd6, 1, 0, 3'b001),
             enc_i(32'd4, 0, 3'b010, 8, LD),
             enc_i(32'd6, 0, 3'b001, 9, LD),
             enc_i(32'd4, 0, 3'b000, 6, LD),
             enc_i(32'd4, 0, 3'b100, 7, LD),
             enc_u(32'h1, 11, 7'b0110111),
             enc_i(32'd0, 11, 3'b010, 10, LD),
             enc_s(32'd8, 5, 0, 3'b001),
             enc_i(32'd8, 0, 3'b001, 12, LD)};
    load_and_reset();
    run(19);
    tests_run++;
    if (dut.registers.registers[2] !== 32'h78) begin
      tests_failed++; $display("FAIL ls_lb got %h want %h", dut.registers.registers[2], 32'h78);
    end
    tests_run++;
    if (dut.registers.registers[3] !== 32'h1234) begin
      tests_failed++; $display("FAIL ls_lhu got %h want %h", dut.registers.registers[3], 32'h1234);
    end
    tests_run++;
    if (dut.registers.registers[4] !== 32'h12340078) begin
      tests_failed++; $display("FAIL ls_sb_lw got %h want %h", dut.registers.registers[4], 32'h12340078);
    end
    tests_run++;
    if (dut.registers.registers[8] !== 32'h56780080) begin
      tests_failed++; $display("FAIL ls_sh_lanes got %h want %h", dut.registers.registers[8], 32'h56780080);
    end
    tests_run++;
    if (dut.registers.registers[9] !== 32'h5678) begin
      tests_failed++; $display("FAIL ls_lh_hi got %h want %h", dut.registers.registers[9], 32'h5678);
    end
    tests_run++;
    if (dut.registers.registers[6] !== 32'hFFFFFF80) begin
      tests_failed++; $display("FAIL ls_lb_neg got %h want %h", dut.registers.registers[6], 32'hFFFFFF80);
    end
    tests_run++;
    if (dut.registers.registers[7] !== 32'h80) begin
      tests_failed++; $display("FAIL ls_lbu got %h want %h", dut.registers.registers[7], 32'h80);
    end
    tests_run++;
    if (dut.registers.registers[10] !== 32'h12340078) begin
      tests_failed++; $display("FAIL ls_wrap got %h want %h", dut.registers.registers[10], 32'h12340078);
    end
    tests_run++;
    if (dut.registers.registers[12] !== 32'hFFFFFF80) begin
      tests_failed++; $display("FAIL ls_lh_neg got %h want %h", dut.registers.registers[12], 32'hFFFFFF80);
    end
  endtask

  task automatic test_branch();
    prog = '{enc_i(32'd1, 0, 3'b000, 1, OPI),         // 0
             enc_b(32'd8, 0, 1, 3'b000),              // 4  BEQ not taken
             enc_i(32'd7, 0, 3'b000, 2, OPI),         // 8
             enc_b(32'd8, 0, 1, 3'b001),              // 12 BNE taken -> 20
             enc_i(32'd9, 0, 3'b000, 3, OPI),         // 16 skipped
             enc_i(32'd4, 0, 3'b000, 4, OPI),         // 20
             enc_i(32'hFFFFFFFF, 0, 3'b000, 5, OPI),  // 24
             enc_b(32'd8, 5, 1, 3'b110),              // 28 BLTU taken -> 36
             enc_i(32'd1, 0, 3'b000, 6, OPI),         // 32 skipped
             enc_b(32'd8, 1, 5, 3'b100),              // 36 BLT taken -> 44
             enc_i(32'd1, 0, 3'b000, 7, OPI),         // 40 skipped
             enc_b(32'd8, 1, 5, 3'b101),              // 44 BGE not taken
             enc_i(32'd3, 0, 3'b000, 8, OPI)};        // 48
    load_and_reset();
    run(10);
    tests_run++;
    if (dut.registers.registers[2] !== 32'd7) begin
      tests_failed++; $display("FAIL br_beq_nt got %h want %h", dut.registers.registers[2], 32'd7);
    end
    tests_run++;
    if (dut.registers.registers[3] !== 32'd0) begin
      tests_failed++; $display("FAIL br_bne_skip got %h want %h", dut.registers.registers[3], 32'd0);
    end
    tests_run++;
    if (dut.registers.registers[4] !== 32'd4) begin
      tests_failed++; $display("FAIL br_target got %h want %h", dut.registers.registers[4], 32'd4);
    end
    tests_run++;
    if (dut.registers.registers[6] !== 32'd0 || dut.registers.registers[7] !== 32'd0) begin
      tests_failed++; $display("FAIL br_signed_skip got %h/%h want 0/0",
                               dut.registers.registers[6], dut.registers.registers[7]);
    end
    tests_run++;
    if (dut.registers.registers[8] !== 32'd3) begin
      tests_failed++; $display("FAIL br_bge_nt got %h want %h", dut.registers.registers[8], 32'd3);
    end
    tests_run++;
    if (dut.pc !== 32'd52) begin
      tests_failed++; $display("FAIL br_pc got %h want %h", dut.pc, 32'd52);
    end
  endtask

  task automatic test_jump();
    prog = '{enc_u(32'h1, 1, 7'b0010111),             // 0  AUIPC
             enc_j(32'd8, 2),                         // 4  JAL -> 12
             enc_i(32'd0, 0, 3'b000, 3, 7'b1100111),  // 8  never reached
             enc_i(32'd25, 0, 3'b000, 4, OPI),        // 12
             enc_i(32'd0, 4, 3'b000, 5, 7'b1100111),  // 16 JALR -> 24
             enc_i(32'd1, 0, 3'b000, 6, OPI),         // 20 skipped
             enc_i(32'd2, 0, 3'b000, 7, OPI)};        // 24
    load_and_reset();
    run(2);
    tests_run++;
    if (dut.registers.registers[1] !== 32'h1000) begin
      tests_failed++; $display("FAIL jmp_auipc got %h want %h", dut.registers.registers[1], 32'h1000);
    end
    tests_run++;
    if (dut.registers.registers[2] !== 32'h8) begin
      tests_failed++; $display("FAIL jmp_jal_link got %h want %h", dut.registers.registers[2], 32'h8);
    end
    tests_run++;
    if (dut.pc !== 32'hC) begin
      tests_failed++; $display("FAIL jmp_jal_pc got %h want %h", dut.pc, 32'hC);
    end
    run(3);
    tests_run++;
    if (dut.registers.registers[5] !== 32'd20 || dut.registers.registers[3] !== 32'd0) begin
      tests_failed++; $display("FAIL jmp_jalr_link got %h/%h want 14/0",
                               dut.registers.registers[5], dut.registers.registers[3]);
    end
    tests_run++;
    if (dut.registers.registers[6] !== 32'd0 || dut.registers.registers[7] !== 32'd2) begin
      tests_failed++; $display("FAIL jmp_jalr_target got %h/%h want 0/2",
                               dut.registers.registers[6], dut.registers.registers[7]);
    end
    tests_run++;
    if (dut.pc !== 32'd28) begin
      tests_failed++; $display("FAIL jmp_pc got %h want %h", dut.pc, 32'd28);
    end
  endtask

  task automatic test_nop();
    prog = '{32'hFFFFFFFF, 32'h00000000, enc_i(32'd1, 0, 3'b000, 1, OPI)};
    load_and_reset();
    run(3);
    tests_run++;
    if (dut.pc !== 32'd12 || dut.registers.registers[1] !== 32'd1) begin
      tests_failed++; $display("FAIL nop_flow got pc=%h x1=%h want pc=c x1=1",
                               dut.pc, dut.registers.registers[1]);
    end
    tests_run++;
    if (dut.registers.registers[31] !== 32'd0) begin
      tests_failed++; $display("FAIL nop_no_write got %h want %h", dut.registers.registers[31], 32'd0);
    end
  endtask

  task automatic test_reset_midrun();
    int bad;
    prog = '{enc_i(32'd5, 0, 3'b000, 1, OPI),
             enc_i(32'd9, 0, 3'b000, 0, OPI),
             enc_i(32'hFFFFFFFF, 0, 3'b000, 31, OPI),
             enc_i(32'd2, 0, 3'b000, 2, OPI),
             enc_i(32'd3, 0, 3'b000, 3, OPI)};
    load_and_reset();
    run(3);
    tests_run++;
    if (dut.registers.registers[31] !== 32'hFFFFFFFF || dut.registers.registers[0] !== 32'd0) begin
      tests_failed++; $display("FAIL rst_pre got x31=%h x0=%h want ffffffff/0",
                               dut.registers.registers[31], dut.registers.registers[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    run(2);
    tests_run++;
    if (dut.pc !== 32'd0) begin
      tests_failed++; $display("FAIL rst_pc got %h want %h", dut.pc, 32'd0);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.registers.registers[i] !== 32'd0) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL rst_regs got %0d nonzero regs want 0", bad);
    end
    @(negedge clk);
    reset = 1'b1;
    run(1);
    tests_run++;
    if (dut.pc !== 32'd4 || dut.registers.registers[1] !== 32'd5) begin
      tests_failed++; $display("FAIL rst_restart got pc=%h x1=%h want 4/5",
                               dut.pc, dut.registers.registers[1]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    test_reset_initial();
    test_rtype();
    test_itype();
    test_loadstore();
    test_branch();
    test_jump();
    test_nop();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rv32i_top.md
# rv32i_top

Single-cycle RV32I processor top level: fetch, decode, register file, ALU, data memory and next-PC logic, all completing one instruction per clock. It is the root of the processor hierarchy. Its only ports are clock and reset; programs are preloaded into instruction memory and results are observed through internal state.

## Interface
- Parameters:
  - IMEM_WORDS, 1024: instruction memory depth in 32-bit words.
  - DMEM_WORDS, 1024: data memory depth in 32-bit words.
- Ports:
  - clk  input  1  clock; all state updates on the rising edge.
  - reset  input  1  synchronous, active-low reset.
- Required internal names, used by benches through hierarchy:
  - pc: 32-bit program counter.
  - instruction: 32-bit current fetched word.
  - instruction_mem.memory: word array [0:IMEM_WORDS-1], loadable by $readmemh.
  - registers.registers: array [0:31] of 32-bit registers.

## Operation
- Fetch:
  - instruction = instruction_mem.memory[pc[11:2]], combinational.
  - The index wraps modulo IMEM_WORDS.
- Supported instructions:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Upper immediates and jumps: LUI, AUIPC, JAL, JALR.
- Immediates are decoded per I, S, B, U and J formats and sign-extended to 32 bits.
- Arithmetic is modulo 2^32. Shifts use the low 5 bits of the shift amount. SRA and SRAI are arithmetic.
- Register file:
  - Two combinational read ports and one write port.
  - x0 always reads 0; writes to x0 are discarded.
- Writeback source:
  - ALU result for R-type and I-type ALU ops.
  - Load data for loads.
  - PC+4 for JAL and JALR.
  - imm for LUI.
  - PC+imm for AUIPC.
- Data memory:
  - Byte address is rs1+imm. Word index is addr[11:2], wrapping modulo DMEM_WORDS.
  - Loads: LB and LH sign-extend; LBU and LHU zero-extend. Byte lane is addr[1:0]; halfword lane is addr[1]. LW ignores addr[1:0].
  - Stores write only the addressed byte or halfword lanes; other bytes are unchanged.
- Next PC:
  - Taken branch and JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - All other cases: pc+4.
- Any unrecognised opcode, including 0x00000000, executes as a NOP: no register write, no memory write, pc+4.

## Timing
- Every instruction completes in one cycle. PC, register write and data memory write all commit on the same rising edge.
- Register and memory reads are combinational.
  - A value written at edge N is visible to the instruction executing after edge N.
- Reset (reset==0 at a rising edge):
  - pc <= 0.
  - All 32 registers <= 0.
  - No data memory write occurs.
  - Instruction and data memory contents are preserved.
- Reset asserted mid-program takes effect at the next edge and discards the in-flight instruction's writes. Execution restarts at address 0 on the first edge with reset==1.
- Instruction memory contents may be replaced while reset is low. Execution uses the new contents immediately after release.

## Configuration
- RV32I_TRACE_EN:
  - When defined, each rising edge with reset==1 and instruction non-zero prints one line via $display: time, pc and instruction, as "PC=0x%08h Instr=0x%08h".
  - When undefined, there is no trace output and the logic is otherwise identical.

## Test plan
- R-type: ADDI x1,x0,5; ADDI x2,x0,3; SUB x3,x1,x2; SLL x4,x1,x2 -> x3=0x00000002, x4=0x00000028.
- I-type and signedness: ADDI x1,x0,-1; SLTIU x2,x1,1; SRAI x3,x1,4 -> x1=0xFFFFFFFF, x2=0, x3=0xFFFFFFFF.
- Load/store: LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,0(x0); LB x2,0(x0); LHU x3,2(x0); SB x0,1(x0); LW x4,0(x0) -> x2=0x00000078, x3=0x00001234, x4=0x12340078.
- Branch: ADDI x1,x0,1; BEQ x1,x0,+8; ADDI x2,x0,7; BNE x1,x0,+8; ADDI x3,x0,9; ADDI x4,x0,4 -> x2=7, x3=0 (skipped), x4=4.
- U/J-type: AUIPC x1,1 at pc 0; JAL x2,+8 at pc 4; JALR x3,0(x0) never reached -> x1=0x00001000, x2=0x00000008, pc continues at 0x0C.
- Reset: run any program, drive reset low for 2 cycles -> pc=0, x1..x31=0, x0 write attempts leave x0=0.
